// File: rtl/game_sequencer.sv
// game_sequencer: frogger-style game flow FSM (lives, level, freeze timing, car speed).
// Optional LEVEL_SPEEDUP_EN shortens the car step period as the level rises.
module game_sequencer #(
  parameter int LIVES_INIT  = 3,
  parameter int MAX_LEVEL   = 9,
  parameter int HIT_CYCLES  = 25000000,
  parameter int WIN_CYCLES  = 25000000,
  parameter int BASE_PERIOD = 12500000,
  parameter int PERIOD_STEP = 1000000,
  parameter int MIN_PERIOD  = 2500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        collision_detected,
  input  logic        frog_at_top,
  output logic        reset_frog,
  output logic        freeze,
  output logic        game_over,
  output logic [1:0]  lives,
  output logic [3:0]  level,
  output logic [23:0] car_period,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, HIT = 3'd2, LEVEL_UP = 3'd3, GAME_OVER = 3'd4} state_t;
  localparam int CMAX = (HIT_CYCLES > WIN_CYCLES) ? HIT_CYCLES : WIN_CYCLES;
  localparam int CW = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;
  state_t cur, nxt;
  logic [1:0] lives_n;
  logic [3:0] level_n;
  logic [CW-1:0] cnt, cnt_n;
  logic start_prev;
  logic start_edge;
  assign start_edge = start & ~start_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= IDLE;
      lives <= 2'(LIVES_INIT);
      level <= 4'd1;
      cnt <= '0;
      start_prev <= 1'b1;
    end else begin
      cur <= nxt;
      lives <= lives_n;
      level <= level_n;
      cnt <= cnt_n;
      start_prev <= start;
    end
  end
  always_comb begin
    nxt = cur;
    lives_n = lives;
    level_n = level;
    cnt_n = cnt;
    if (cur == IDLE || cur == GAME_OVER) begin
      if (start_edge) begin
        nxt = PLAY;
        lives_n = 2'(LIVES_INIT);
        level_n = 4'd1;
      end
    end else if (cur == PLAY) begin
      if (collision_detected) begin
        cnt_n = '0;
        lives_n = (lives > 2'd1) ? lives - 2'd1 : 2'd0;
        nxt = (lives > 2'd1) ? HIT : GAME_OVER;
      end else if (frog_at_top) begin
        cnt_n = '0;
        level_n = (level >= 4'(MAX_LEVEL)) ? level : level + 4'd1;
        nxt = LEVEL_UP;
      end
    end else if (cur == HIT || cur == LEVEL_UP) begin
      if (cnt == ((cur == HIT) ? CW'(HIT_CYCLES - 1) : CW'(WIN_CYCLES - 1))) begin
        cnt_n = '0;
        nxt = PLAY;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else begin
      nxt = IDLE;
    end
  end
  assign state = cur;
  assign reset_frog = (cur != PLAY);
  assign freeze = (cur != PLAY);
  assign game_over = (cur == GAME_OVER);
`ifdef LEVEL_SPEEDUP_EN
  logic [31:0] dec;
  assign dec = 32'(level - 4'd1) * 32'(PERIOD_STEP);
  assign car_period = (32'(BASE_PERIOD) >= 32'(MIN_PERIOD) + dec) ? 24'(32'(BASE_PERIOD) - dec) : 24'(MIN_PERIOD);
`else
  assign car_period = 24'(BASE_PERIOD);
`endif
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: table-driven, scoreboarded check of game_sequencer with short freeze timers.
module tb_game_sequencer;
  logic clk = 0, rst = 1, start = 1, coll = 0, top = 0;
  logic reset_frog, freeze, game_over;
  logic [1:0] lives;
  logic [3:0] level;
  logic [23:0] car_period;
  logic [2:0] state;
  int compared = 0, mismatched = 0;

  game_sequencer #(.LIVES_INIT(3), .HIT_CYCLES(4), .WIN_CYCLES(6)) dut (
    .clk(clk), .rst(rst), .start(start), .collision_detected(coll), .frog_at_top(top),
    .reset_frog(reset_frog), .freeze(freeze), .game_over(game_over),
    .lives(lives), .level(level), .car_period(car_period), .state(state));

  always #5 clk = ~clk;

  typedef struct {
    logic r, s, c, t;
    logic [2:0] st;
    logic [1:0] lv;
    logic [3:0] lvl;
  } vec_t;
  typedef struct {
    logic [2:0] st;
    logic [1:0] lv;
    logic [3:0] lvl;
    logic fr, rf, go;
    logic [23:0] cp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic logic [23:0] exp_cp(input int lvl);
`ifdef LEVEL_SPEEDUP_EN
    int p = 12500000 - (lvl - 1) * 1000000;
    return 24'((p < 2500000) ? 2500000 : p);
`else
    return 24'(12500000 + 0 * lvl);
`endif
  endfunction

  task automatic add(input logic r, s, c, t, input int st, lv, lvl);
    vec_t v;
    v.r = r; v.s = s; v.c = c; v.t = t;
    v.st = 3'(st); v.lv = 2'(lv); v.lvl = 4'(lvl);
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    int lvl;
    // reset with start held, then start held after reset: no edge
    add(1, 1, 0, 0, 0, 3, 1); add(1, 1, 0, 0, 0, 3, 1);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, 3, 1);
    add(0, 0, 1, 1, 0, 3, 1);
    add(0, 1, 0, 0, 1, 3, 1);
    add(0, 0, 0, 0, 1, 3, 1);
    // hit: 4 cycles frozen
    add(0, 0, 1, 0, 2, 2, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 2, 2, 1);
    add(0, 0, 0, 0, 1, 2, 1);
    // simultaneous collision and top: collision wins
    add(0, 0, 1, 1, 2, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 2, 1, 1);
    add(0, 0, 0, 0, 1, 1, 1);
    // level up: 6 cycles frozen
    add(0, 0, 0, 1, 3, 1, 2);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 3, 1, 2);
    add(0, 0, 0, 0, 1, 1, 2);
    // last life lost
    add(0, 0, 1, 0, 4, 0, 2);
    add(0, 0, 1, 1, 4, 0, 2);
    add(0, 0, 0, 0, 4, 0, 2);
    add(0, 1, 0, 0, 1, 3, 1);
    add(0, 0, 0, 0, 1, 3, 1);
    // ten top arrivals, level saturates
    lvl = 1;
    for (int i = 0; i < 10; i++) begin
      lvl = (lvl < 9) ? lvl + 1 : 9;
      add(0, 0, 0, 1, 3, 3, lvl);
      for (int j = 0; j < 5; j++) add(0, 0, 0, 0, 3, 3, lvl);
      add(0, 0, 0, 0, 1, 3, lvl);
    end
    // reset mid-HIT at count 2
    add(0, 0, 1, 0, 2, 2, 9);
    add(0, 0, 0, 0, 2, 2, 9);
    add(0, 0, 0, 0, 2, 2, 9);
    add(1, 0, 0, 0, 0, 3, 1);
    add(0, 0, 0, 0, 0, 3, 1);
    add(0, 1, 0, 0, 1, 3, 1);
    add(0, 0, 0, 0, 1, 3, 1);
    add(0, 1, 0, 0, 1, 3, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; start = tbl[i].s; coll = tbl[i].c; top = tbl[i].t;
      e.st = tbl[i].st; e.lv = tbl[i].lv; e.lvl = tbl[i].lvl;
      e.fr = (tbl[i].st != 3'd1); e.rf = (tbl[i].st != 3'd1); e.go = (tbl[i].st == 3'd4);
      e.cp = exp_cp(int'(tbl[i].lvl));
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("state[%0d]", i), 32'(state), 32'(e.st));
      chk($sformatf("lives[%0d]", i), 32'(lives), 32'(e.lv));
      chk($sformatf("level[%0d]", i), 32'(level), 32'(e.lvl));
      chk($sformatf("freeze[%0d]", i), 32'(freeze), 32'(e.fr));
      chk($sformatf("reset_frog[%0d]", i), 32'(reset_frog), 32'(e.rf));
      chk($sformatf("game_over[%0d]", i), 32'(game_over), 32'(e.go));
      chk($sformatf("car_period[%0d]", i), 32'(car_period), 32'(e.cp));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
